// File: rtl/keyboard_pkg.sv
// Shared key codes, register map and status layout for the keyboard buffer.
package keyboard_pkg;

    localparam logic [7:0] KEY_NULL  = 8'd0;
    localparam logic [7:0] KEY_ESC   = 8'd255;
    localparam logic [7:0] KEY_UP    = 8'd17;
    localparam logic [7:0] KEY_LEFT  = 8'd18;
    localparam logic [7:0] KEY_DOWN  = 8'd19;
    localparam logic [7:0] KEY_RIGHT = 8'd20;
    localparam logic [7:0] KEY_ENTER = 8'd10;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_STAT = 1'b1;

    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_IRQEN  = 1;
    localparam int CTRL_CLROVF = 7;

    typedef struct packed {
        logic       ovf;
        logic       full;
        logic       empty;
        logic [4:0] count;
    } status_t;

    // Deep FIFOs report a pinned 5'h1F rather than a wrapped count.
    function automatic logic [4:0] sat_count5(input logic [31:0] c);
        return (c > 32'd31) ? 5'h1F : c[4:0];
    endfunction

endpackage

// File: rtl/key_fifo.sv
// DEPTH-entry synchronous FIFO for key codes; pop frees a slot for a same-cycle push.
module key_fifo
    import keyboard_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/key_buffer.sv
// Key code FIFO with a two-register CPU port (DATA, STATUS/CTRL) and a pending-key interrupt.
module key_buffer
    import keyboard_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       key_req,
    input  logic [7:0] key_code,
    input  logic       cpu_sel,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic       cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    output logic       irq
);
    logic             rd_acc, wr_acc, ctrl_wr;
    logic             key_push, fifo_pop, fifo_flush, ovf_set;
    logic [7:0]       fifo_dout;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    status_t          status;

    logic       ovf_q, ovf_d;
    logic       irq_en_q, irq_en_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_q, ack_d;
    logic       irq_q, irq_d;

    logic unused_wdata;
    assign unused_wdata = ^cpu_wdata[6:2];

    // A simultaneous rd+wr is served as a read.
    assign rd_acc     = cpu_sel & cpu_rd;
    assign wr_acc     = cpu_sel & cpu_wr & ~cpu_rd;
    assign ctrl_wr    = wr_acc & (cpu_addr == ADDR_STAT);
    assign key_push   = key_req & (key_code != KEY_NULL);
    assign fifo_pop   = rd_acc & (cpu_addr == ADDR_DATA);
    assign fifo_flush = ctrl_wr & cpu_wdata[CTRL_FLUSH];
    assign ovf_set    = key_push & fifo_full & ~fifo_pop & ~fifo_flush;

    key_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk   (sys_clk),
        .rst_n (reset_n),
        .push  (key_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (key_code),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign status = '{ovf:   ovf_q,
                      full:  fifo_full,
                      empty: fifo_empty,
                      count: sat_count5(32'(fifo_count))};

    always_comb begin
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        rdata_d  = rdata_q;
        ack_d    = rd_acc | wr_acc;
        irq_d    = irq_en_q & ~fifo_empty;
        if (ctrl_wr) begin
            irq_en_d = cpu_wdata[CTRL_IRQEN];
            if (cpu_wdata[CTRL_CLROVF]) ovf_d = 1'b0;
        end
        if (ovf_set) ovf_d = 1'b1;
        if (rd_acc) begin
            if (cpu_addr == ADDR_DATA) rdata_d = fifo_empty ? 8'h00 : fifo_dout;
            else                       rdata_d = status;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b1;
            rdata_q  <= 8'h00;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            irq_q    <= irq_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_key_buffer.sv
// Directed bench for key_buffer: ordering, overflow, full push+pop, irq control, reset, wrap.
module tb_key_buffer;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_req = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       cpu_sel = 1'b0;
    logic       cpu_rd = 1'b0;
    logic       cpu_wr = 1'b0;
    logic       cpu_addr = 1'b0;
    logic [7:0] cpu_wdata = 8'h00;
    logic [7:0] cpu_rdata;
    logic       cpu_ack;
    logic       irq;

    int n_cmp = 0;
    int n_err = 0;

    key_buffer #(.DEPTH(16), .CNT_W(5)) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .key_req   (key_req),
        .key_code  (key_code),
        .cpu_sel   (cpu_sel),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .irq       (irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] code);
        key_req = 1'b1; key_code = code;
        tick(1);
        key_req = 1'b0; key_code = 8'h00;
    endtask

    task automatic cpu_read(input logic addr, output logic [7:0] data, output logic ack);
        cpu_sel = 1'b1; cpu_rd = 1'b1; cpu_addr = addr;
        tick(1);
        cpu_sel = 1'b0; cpu_rd = 1'b0;
        data = cpu_rdata; ack = cpu_ack;
    endtask

    task automatic cpu_write(input logic addr, input logic [7:0] data, output logic ack);
        cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_addr = addr; cpu_wdata = data;
        tick(1);
        cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00;
        ack = cpu_ack;
    endtask

    task automatic test_reset();
        logic [7:0] d; logic a;
        do_reset();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
        n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b exp=0", cpu_ack); end
        n_cmp++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata got=%h exp=00", cpu_rdata); end
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'h20 || a !== 1'b1) begin n_err++; $display("FAIL reset_status got=%h ack=%b exp=20 ack=1", d, a); end
    endtask

    task automatic test_fifo_order();
        logic [7:0] d; logic a;
        logic [7:0] codes [3] = '{8'h41, 8'h42, 8'h43};
        do_reset();
        foreach (codes[i]) push(codes[i]);
        // three entries pending: empty clear, count 3
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'h03) begin n_err++; $display("FAIL order_status got=%h exp=03", d); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL order_irq_high got=%b exp=1", irq); end
        foreach (codes[i]) begin
            cpu_read(1'b0, d, a);
            n_cmp++; if (d !== codes[i] || a !== 1'b1) begin n_err++; $display("FAIL order_data%0d got=%h ack=%b exp=%h ack=1", i, d, a, codes[i]); end
        end
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'h20) begin n_err++; $display("FAIL order_empty got=%h exp=20", d); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL order_irq_low got=%b exp=0", irq); end
    endtask

    task automatic test_overflow();
        logic [7:0] d; logic a;
        do_reset();
        for (int i = 1; i <= 17; i++) push(8'(i));
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'hD0) begin n_err++; $display("FAIL ovf_status got=%h exp=d0", d); end
        cpu_write(1'b1, 8'h82, a);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL ovf_wr_ack got=%b exp=1", a); end
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'h50) begin n_err++; $display("FAIL ovf_cleared got=%h exp=50", d); end
        // overflow event and clear in the same cycle: set wins
        key_req = 1'b1; key_code = 8'h63;
        cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_addr = 1'b1; cpu_wdata = 8'h82;
        tick(1);
        key_req = 1'b0; key_code = 8'h00; cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00;
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'hD0) begin n_err++; $display("FAIL ovf_set_wins got=%h exp=d0", d); end
        for (int i = 1; i <= 16; i++) begin
            cpu_read(1'b0, d, a);
            n_cmp++; if (d !== 8'(i) || a !== 1'b1) begin n_err++; $display("FAIL ovf_data%0d got=%h ack=%b exp=%h", i, d, a, 8'(i)); end
        end
        cpu_read(1'b0, d, a);
        n_cmp++; if (d !== 8'h00 || a !== 1'b1) begin n_err++; $display("FAIL ovf_empty_read got=%h ack=%b exp=00 ack=1", d, a); end
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'hA0) begin n_err++; $display("FAIL ovf_sticky got=%h exp=a0", d); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d; logic a;
        do_reset();
        for (int i = 1; i <= 16; i++) push(8'(i));
        key_req = 1'b1; key_code = 8'h55;
        cpu_sel = 1'b1; cpu_rd = 1'b1; cpu_addr = 1'b0;
        tick(1);
        key_req = 1'b0; key_code = 8'h00; cpu_sel = 1'b0; cpu_rd = 1'b0;
        n_cmp++; if (cpu_rdata !== 8'h01 || cpu_ack !== 1'b1) begin n_err++; $display("FAIL fpp_first got=%h ack=%b exp=01 ack=1", cpu_rdata, cpu_ack); end
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'h50) begin n_err++; $display("FAIL fpp_status got=%h exp=50", d); end
        for (int i = 2; i <= 17; i++) begin
            cpu_read(1'b0, d, a);
            if (i == 17) begin
                n_cmp++; if (d !== 8'h55) begin n_err++; $display("FAIL fpp_last got=%h exp=55", d); end
            end else begin
                n_cmp++; if (d !== 8'(i)) begin n_err++; $display("FAIL fpp_data%0d got=%h exp=%h", i, d, 8'(i)); end
            end
        end
    endtask

    task automatic test_null_irqen();
        logic [7:0] d; logic a;
        do_reset();
        push(8'h00);
        tick(2);
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'h20) begin n_err++; $display("FAIL null_status got=%h exp=20", d); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL null_irq got=%b exp=0", irq); end
        push(8'h0A);
        tick(1);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irqen_on got=%b exp=1", irq); end
        cpu_write(1'b1, 8'h00, a);
        tick(1);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irqen_masked got=%b exp=0", irq); end
        cpu_write(1'b1, 8'h02, a);
        tick(1);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irqen_restored got=%b exp=1", irq); end
        cpu_write(1'b0, 8'hFF, a);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL data_wr_ack got=%b exp=1", a); end
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'h01) begin n_err++; $display("FAIL data_wr_ignored got=%h exp=01", d); end
    endtask

    task automatic test_ctrl_reset();
        logic [7:0] d; logic a;
        do_reset();
        for (int i = 1; i <= 17; i++) push(8'(i));
        for (int i = 0; i < 11; i++) cpu_read(1'b0, d, a);
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'h85) begin n_err++; $display("FAIL ctrl_pre got=%h exp=85", d); end
        // flush + clear overflow, with a push in the same cycle that must be lost
        key_req = 1'b1; key_code = 8'h77;
        cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_addr = 1'b1; cpu_wdata = 8'h81;
        tick(1);
        key_req = 1'b0; key_code = 8'h00; cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00;
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'h20) begin n_err++; $display("FAIL ctrl_flush got=%h exp=20", d); end
        push(8'h13); push(8'h14);
        cpu_write(1'b1, 8'h02, a);
        tick(2);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL midrst_pre_irq got=%b exp=1", irq); end
        reset_n = 1'b0; cpu_sel = 1'b1; cpu_rd = 1'b1; cpu_addr = 1'b0;
        tick(1);
        n_cmp++; if (cpu_ack !== 1'b0 || irq !== 1'b0) begin n_err++; $display("FAIL midrst_out ack=%b irq=%b exp ack=0 irq=0", cpu_ack, irq); end
        reset_n = 1'b1; cpu_sel = 1'b0; cpu_rd = 1'b0;
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'h20) begin n_err++; $display("FAIL midrst_status got=%h exp=20", d); end
    endtask

    task automatic test_latency_wrap();
        logic [7:0] d; logic a;
        do_reset();
        push(8'h11);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL lat_n1 got=%b exp=0", irq); end
        tick(1);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL lat_n2 got=%b exp=1", irq); end
        for (int i = 0; i < 40; i++) begin
            key_req = 1'b1; key_code = 8'(i + 32);
            cpu_sel = 1'b1; cpu_rd = 1'b1; cpu_addr = 1'b0;
            tick(1);
            key_req = 1'b0; cpu_sel = 1'b0; cpu_rd = 1'b0;
            n_cmp++; if (cpu_rdata !== ((i == 0) ? 8'h11 : 8'(i + 31))) begin n_err++; $display("FAIL wrap%0d got=%h exp=%h", i, cpu_rdata, (i == 0) ? 8'h11 : 8'(i + 31)); end
        end
        cpu_read(1'b0, d, a);
        n_cmp++; if (d !== 8'd71) begin n_err++; $display("FAIL wrap_last got=%h exp=47", d); end
        cpu_read(1'b1, d, a);
        n_cmp++; if (d !== 8'h20 || irq !== 1'b0) begin n_err++; $display("FAIL wrap_end got=%h irq=%b exp=20 irq=0", d, irq); end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_overflow();
        test_full_push_pop();
        test_null_irqen();
        test_ctrl_reset();
        test_latency_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
